// File: rtl/loader_pkg.sv
// Shared constants and state type for the input vector loader.
package loader_pkg;

    localparam int VEC_W     = 1894;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 60;
    localparam int LAST_BITS = 6;
    localparam int CNT_W     = 6;

    // Bit-index width for addressing into the assembled vector.
    localparam int IDX_W     = $clog2(VEC_W);

    // S_LOAD: collecting words, shadow not yet complete.
    // S_FULL: shadow holds a complete frame waiting for a publish slot.
    // S_DROP: one cycle after a malformed frame was dropped; drives frame_err
    //         and otherwise behaves like S_LOAD.
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_DROP = 2'd2
    } loader_state_t;

endpackage

// File: rtl/input_vector_loader.sv
// Assembles 60 upstream 32-bit words into a 1894-bit vector, double-buffered
// behind a shadow register so a new frame can load while the published one
// waits for vec_ack. Malformed frames are dropped and counted.
module input_vector_loader
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [VEC_W-1:0]     vec_o,
    output logic                 vec_valid,
    input  logic                 vec_ack,
    output logic                 frame_err,
    output logic [7:0]           err_cnt,
    output logic [15:0]          pub_cnt
);

    loader_state_t     state;
    loader_state_t     state_next;

    logic [CNT_W-1:0]  word_cnt;
    logic [VEC_W-1:0]  shadow;
    logic [VEC_W-1:0]  shadow_next;
    logic [IDX_W-1:0]  word_base;

    logic              accept;
    logic              at_last_word;
    logic              malformed;
    logic              complete;
    logic              slot_open;
    logic              transfer;

    // A frame is well formed only when in_last coincides exactly with word 59.
    assign in_ready     = (state != S_FULL);
    assign accept       = in_valid && in_ready;
    assign at_last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));
    assign malformed    = accept && (in_last != at_last_word);
    assign complete     = accept && in_last && at_last_word;
    assign slot_open    = !vec_valid || vec_ack;
    assign transfer     = slot_open && (complete || (state == S_FULL));
    assign word_base    = IDX_W'(word_cnt) * IDX_W'(WORD_W);
    assign frame_err    = (state == S_DROP);

    // Shadow image including the word accepted this cycle, so a completing
    // frame can be published on the same edge that accepts its last word.
    always_comb begin
        shadow_next = shadow;
        if (accept) begin
            if (at_last_word) begin
                shadow_next[VEC_W-1 -: LAST_BITS] = in_data[LAST_BITS-1:0];
            end else begin
                shadow_next[word_base +: WORD_W] = in_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: drop on a malformed word, park in FULL when a completed
    // frame finds the publish slot closed, leave FULL as soon as it opens.
    always_comb begin
        state_next = state;
        unique case (state)
            S_LOAD, S_DROP: begin
                if (malformed) begin
                    state_next = S_DROP;
                end else if (complete && !slot_open) begin
                    state_next = S_FULL;
                end else begin
                    state_next = S_LOAD;
                end
            end
            S_FULL: begin
                if (slot_open) begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Word counter and shadow storage; the counter restarts after word 59 or
    // after a malformed word so the next word is always treated as word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            shadow   <= '0;
        end else if (accept) begin
            shadow <= shadow_next;
            if (malformed || complete) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    // Published vector, its valid flag and the publish/error counters. A
    // transfer on the same edge as vec_ack keeps vec_valid high with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_o     <= '0;
            vec_valid <= 1'b0;
            pub_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            if (transfer) begin
                vec_o     <= shadow_next;
                vec_valid <= 1'b1;
                pub_cnt   <= pub_cnt + 16'd1;
            end else if (vec_ack) begin
                vec_valid <= 1'b0;
            end
            if (malformed && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_input_vector_loader.sv
// Directed testbench for input_vector_loader.
module tb_input_vector_loader;
    import loader_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [WORD_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [VEC_W-1:0]     vec_o;
    logic                 vec_valid;
    logic                 vec_ack;
    logic                 frame_err;
    logic [7:0]           err_cnt;
    logic [15:0]          pub_cnt;

    int checks_total  = 0;
    int checks_passed = 0;

    input_vector_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .vec_o     (vec_o),
        .vec_valid (vec_valid),
        .vec_ack   (vec_ack),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .pub_cnt   (pub_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One idle cycle with the given reset and ack levels.
    task automatic apply_stimulus(input logic rst_v, input logic ack_v);
        rst     = rst_v;
        vec_ack = ack_v;
        tick();
        rst     = 1'b0;
        vec_ack = 1'b0;
    endtask

    // Present one word, waiting (bounded) for in_ready first.
    task automatic send_word(input logic [31:0] d, input logic last);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) check_output("in_ready_timeout", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Words 0..58 are base+k; word 59 is last_word with in_last = last_flag.
    task automatic send_frame(input logic [31:0] base, input logic [31:0] last_word,
                              input logic last_flag);
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            send_word(base + 32'(k), 1'b0);
        end
        send_word(last_word, last_flag);
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        vec_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst_vec_valid", vec_valid, 0);
        check_output("rst_frame_err", frame_err, 0);
        check_output("rst_err_cnt", err_cnt, 0);
        check_output("rst_pub_cnt", pub_cnt, 0);
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_vec_ones", $countones(vec_o), 0);

        $display("[TB] scenario 1: first frame publishes immediately");
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            send_word(32'(k + 1), 1'b0);
        end
        check_output("s1_not_valid_before_last", vec_valid, 0);
        send_word(32'hFFFF_FFC5, 1'b1);
        check_output("s1_vec_valid", vec_valid, 1);
        check_output("s1_word0", vec_o[31:0], 32'h1);
        check_output("s1_word1", vec_o[63:32], 32'h2);
        check_output("s1_word58", vec_o[1887:1856], 32'd59);
        check_output("s1_last_bits", vec_o[1893:1888], 6'h05);
        check_output("s1_pub_cnt", pub_cnt, 1);
        check_output("s1_in_ready", in_ready, 1);

        $display("[TB] scenario 2: second frame waits for ack");
        send_frame(32'h100, 32'hABCD_EF2A, 1'b1);
        check_output("s2_in_ready_low", in_ready, 0);
        check_output("s2_valid_held", vec_valid, 1);
        check_output("s2_old_word0", vec_o[31:0], 32'h1);
        check_output("s2_pub_cnt_wait", pub_cnt, 1);
        apply_stimulus(1'b0, 1'b1);
        check_output("s2_valid_no_gap", vec_valid, 1);
        check_output("s2_new_word0", vec_o[31:0], 32'h100);
        check_output("s2_new_word58", vec_o[1887:1856], 32'h13A);
        check_output("s2_new_last_bits", vec_o[1893:1888], 6'h2A);
        check_output("s2_pub_cnt", pub_cnt, 2);
        check_output("s2_in_ready_back", in_ready, 1);

        $display("[TB] scenario 3: early in_last on word 10");
        for (int k = 0; k < 10; k++) begin
            send_word(32'h500 + 32'(k), 1'b0);
        end
        send_word(32'hDEAD, 1'b1);
        check_output("s3_frame_err", frame_err, 1);
        check_output("s3_err_cnt", err_cnt, 1);
        check_output("s3_vec_kept", vec_o[31:0], 32'h100);
        check_output("s3_valid_kept", vec_valid, 1);
        apply_stimulus(1'b0, 1'b0);
        check_output("s3_frame_err_pulse", frame_err, 0);
        apply_stimulus(1'b0, 1'b1);
        check_output("s3_ack_clears_valid", vec_valid, 0);
        apply_stimulus(1'b0, 1'b1);
        check_output("s3_ack_ignored", vec_valid, 0);
        check_output("s3_pub_cnt_hold", pub_cnt, 2);
        send_frame(32'h200, 32'h15, 1'b1);
        check_output("s3_next_valid", vec_valid, 1);
        check_output("s3_next_word0", vec_o[31:0], 32'h200);
        check_output("s3_next_word1", vec_o[63:32], 32'h201);
        check_output("s3_next_last_bits", vec_o[1893:1888], 6'h15);
        check_output("s3_pub_cnt", pub_cnt, 3);

        $display("[TB] scenario 4: word 59 without in_last");
        send_frame(32'h300, 32'h3F, 1'b0);
        check_output("s4_frame_err", frame_err, 1);
        check_output("s4_err_cnt", err_cnt, 2);
        check_output("s4_pub_cnt", pub_cnt, 3);
        check_output("s4_vec_kept", vec_o[31:0], 32'h200);
        check_output("s4_in_ready", in_ready, 1);
        apply_stimulus(1'b0, 1'b0);
        check_output("s4_frame_err_pulse", frame_err, 0);
        check_output("s4_valid_kept", vec_valid, 1);

        $display("[TB] scenario 5: reset mid-frame then all-ones frame");
        for (int k = 0; k < 30; k++) begin
            send_word(32'hA5A5_0000 + 32'(k), 1'b0);
        end
        rst      = 1'b1;
        in_data  = 32'h1234;
        in_valid = 1'b1;
        in_last  = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_output("s5_rst_valid", vec_valid, 0);
        check_output("s5_rst_frame_err", frame_err, 0);
        check_output("s5_rst_err_cnt", err_cnt, 0);
        check_output("s5_rst_pub_cnt", pub_cnt, 0);
        check_output("s5_rst_vec_ones", $countones(vec_o), 0);
        check_output("s5_rst_in_ready", in_ready, 1);
        for (int k = 0; k < NUM_WORDS; k++) begin
            send_word(32'hFFFF_FFFF, (k == NUM_WORDS - 1));
        end
        check_output("s5_valid", vec_valid, 1);
        check_output("s5_vec_ones", $countones(vec_o), VEC_W);
        check_output("s5_frame_err", frame_err, 0);
        check_output("s5_err_cnt", err_cnt, 0);
        check_output("s5_pub_cnt", pub_cnt, 1);

        $display("[TB] scenario 6: err_cnt saturation");
        send_word(32'h0, 1'b1);
        check_output("s6_err_cnt_first", err_cnt, 1);
        for (int k = 1; k < 255; k++) begin
            send_word(32'(k), 1'b1);
        end
        check_output("s6_err_cnt_255", err_cnt, 255);
        send_word(32'hFF, 1'b1);
        check_output("s6_err_cnt_sat", err_cnt, 255);
        check_output("s6_frame_err", frame_err, 1);
        apply_stimulus(1'b0, 1'b0);
        check_output("s6_frame_err_end", frame_err, 0);
        check_output("s6_pub_cnt", pub_cnt, 1);
        check_output("s6_vec_kept", $countones(vec_o), VEC_W);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
